// File: rtl/matrix_pkg.sv
// matrix_pkg: shared FSM states and element-width helpers for the tiled matrix adder.
package matrix_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int elem_w(input int width);
        return 2 * width;
    endfunction

    // Clamp a wide signed value into the signed range of an ew-bit element.
    function automatic logic signed [64:0] sat_trunc(input logic signed [64:0] v, input int ew);
        logic signed [64:0] hi, lo;
        hi = (65'sd1 <<< (ew - 1)) - 65'sd1;
        lo = -hi - 65'sd1;
        return v > hi ? hi : v < lo ? lo : v;
    endfunction

endpackage

// File: rtl/matrix_add_tile.sv
// matrix_add_tile: combinational TILE x TILE shift/add/sub with per-element overflow.
// MATRIX_ADD_SAT_EN selects clamping instead of wrap on overflow.
module matrix_add_tile
    import matrix_pkg::*;
#(
    parameter int EW   = 32,
    parameter int TILE = 4
) (
    input  logic [TILE-1:0][TILE-1:0][EW-1:0] a,
    input  logic [TILE-1:0][TILE-1:0][EW-1:0] b,
    input  logic [4:0]                        sh_a,
    input  logic [4:0]                        sh_b,
    input  logic                              flag,
    output logic [TILE-1:0][TILE-1:0][EW-1:0] c,
    output logic [TILE*TILE-1:0]              ovf
);

    for (genvar i = 0; i < TILE; i++) begin : g_row
        for (genvar j = 0; j < TILE; j++) begin : g_col
            logic signed [EW:0] ap, bp, s;
            assign ap = (EW+1)'($signed(a[i][j]) >>> sh_a);
            assign bp = (EW+1)'($signed(b[i][j]) >>> sh_b);
            assign s  = flag ? ap - bp : ap + bp;
            assign ovf[i*TILE+j] = s[EW] ^ s[EW-1];
`ifdef MATRIX_ADD_SAT_EN
            assign c[i][j] = EW'(sat_trunc(65'(s), EW));
`else
            assign c[i][j] = s[EW-1:0];
`endif
        end
    end

endmodule

// File: rtl/matrix_add_tiled.sv
// matrix_add_tiled: sequential NxN signed matrix add/sub, one TILE x TILE block per clock.
// Define MATRIX_ADD_SAT_EN to saturate overflowing elements instead of wrapping.
module matrix_add_tiled
    import matrix_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 8,
    parameter int TILE  = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [N-1:0][N-1:0][elem_w(WIDTH)-1:0] A,
    input  logic [N-1:0][N-1:0][elem_w(WIDTH)-1:0] B,
    input  logic [4:0]                            m_bit1,
    input  logic [4:0]                            m_bit2,
    input  logic                                  flag,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [N-1:0][N-1:0][elem_w(WIDTH)-1:0] C,
    output logic                                  ovf
);

    localparam int EW = elem_w(WIDTH);
    localparam int NT = N / TILE;
    localparam int TW = NT > 1 ? $clog2(NT) : 1;
    localparam int IW = N > 1 ? $clog2(N) : 1;

    if (TILE < 1 || N % TILE != 0) begin : g_bad_cfg
        $error("matrix_add_tiled: N must be a positive multiple of TILE");
    end

    state_t                            state, state_n;
    logic [N-1:0][N-1:0][EW-1:0]       a_q, b_q;
    logic [4:0]                        sh1_q, sh2_q;
    logic                              flag_q;
    logic [TW-1:0]                     tr, tc;
    logic                              last_c, last;
    logic [IW-1:0]                     r0, c0;
    logic [TILE-1:0][TILE-1:0][EW-1:0] a_t, b_t, c_t;
    logic [TILE*TILE-1:0]              ovf_v;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign last_c    = tc == TW'(NT - 1);
    assign last      = last_c && tr == TW'(NT - 1);
    assign r0        = IW'(tr * TILE);
    assign c0        = IW'(tc * TILE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (in_valid ? RUN : IDLE)
                : state == RUN  ? (last ? DONE : RUN)
                :                 (out_ready ? IDLE : DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            sh1_q  <= '0;
            sh2_q  <= '0;
            flag_q <= 1'b0;
            tr     <= '0;
            tc     <= '0;
            ovf    <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_q    <= A;
            b_q    <= B;
            sh1_q  <= m_bit1;
            sh2_q  <= m_bit2;
            flag_q <= flag;
            tr     <= '0;
            tc     <= '0;
            ovf    <= 1'b0;
        end else if (state == RUN) begin
            ovf <= ovf | (|ovf_v);
            tc  <= last_c ? '0 : tc + 1'b1;
            if (last_c) tr <= tr + 1'b1;
        end
    end

    // Both operand tiles are always gathered from the same position.
    for (genvar i = 0; i < TILE; i++) begin : g_gr
        for (genvar j = 0; j < TILE; j++) begin : g_gc
            assign a_t[i][j] = a_q[r0 + IW'(i)][c0 + IW'(j)];
            assign b_t[i][j] = b_q[r0 + IW'(i)][c0 + IW'(j)];
        end
    end

    matrix_add_tile #(.EW(EW), .TILE(TILE)) u_tile (
        .a    (a_t),
        .b    (b_t),
        .sh_a (sh1_q),
        .sh_b (sh2_q),
        .flag (flag_q),
        .c    (c_t),
        .ovf  (ovf_v)
    );

    // Each result element loads only while its own tile is in flight.
    for (genvar r = 0; r < N; r++) begin : g_cr
        for (genvar c = 0; c < N; c++) begin : g_cc
            logic [EW-1:0] q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) q <= '0;
                else if (state == RUN && tr == TW'(r / TILE) && tc == TW'(c / TILE)) q <= c_t[r % TILE][c % TILE];
            end
            assign C[r][c] = q;
        end
    end

endmodule

// File: tb/tb_matrix_add_tiled.sv
// tb_matrix_add_tiled: scoreboard bench for matrix_add_tiled with directed vectors.
module tb_matrix_add_tiled;

    localparam int W  = 16;
    localparam int N  = 8;
    localparam int TL = 4;
    localparam int EW = 32;
    localparam int T  = 4;

    typedef logic [N-1:0][N-1:0][EW-1:0] mat_t;
    typedef struct {
        mat_t c;
        logic o;
    } exp_t;

    logic       clk = 0, rst_n = 0, in_valid = 0, out_ready = 1, flag = 0;
    logic       in_ready, out_valid, ovf;
    logic [4:0] m_bit1 = 0, m_bit2 = 0;
    mat_t       A = '0, B = '0, C;
    mat_t       ma, mb, me;
    exp_t       q[$];
    exp_t       e;
    int         checks = 0, errors = 0, cyc = 0, acc_cyc = 0;
    logic       ov_prev = 0;

    matrix_add_tiled #(.WIDTH(W), .N(N), .TILE(TL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .m_bit1    (m_bit1),
        .m_bit2    (m_bit2),
        .flag      (flag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .C         (C),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk1(input string nm, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkm(input string nm, input mat_t act, input mat_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    if (act[r][c] !== exp[r][c]) begin
                        $display("FAIL %s at [%0d][%0d] got %h expected %h", nm, r, c, act[r][c], exp[r][c]);
                        return;
                    end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && !ov_prev) chk1("latency", cyc - acc_cyc, T);
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output got out_valid with empty scoreboard expected none");
            end else begin
                e = q.pop_front();
                chkm("C", C, e.c);
                chk1("ovf", ovf, e.o);
            end
        end
        ov_prev <= out_valid;
    end

    task automatic send(input mat_t a, input mat_t b, input logic [4:0] s1, input logic [4:0] s2,
                        input logic f, input mat_t ec, input logic eo);
        chk1("in_ready_idle", in_ready, 1);
        q.push_back('{ec, eo});
        A = a; B = b; m_bit1 = s1; m_bit2 = s2; flag = f; in_valid = 1;
        @(posedge clk); #1;
        acc_cyc = cyc;
        in_valid = 0; A = '1; B = '1; m_bit1 = 5'd7; m_bit2 = 5'd7; flag = ~f;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && q.size() != 0; i++) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        #23;
        chk1("rst_out_valid", out_valid, 0);
        chk1("rst_ovf", ovf, 0);
        chk1("rst_in_ready", in_ready, 1);
        chkm("rst_C", C, '0);
        rst_n = 1;
        @(posedge clk); #1;

        // Tile mapping: C = 1000 + 2*(8r+c)
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = 8 * r + c;
                mb[r][c] = 1000 + 8 * r + c;
                me[r][c] = 1000 + 2 * (8 * r + c);
            end
        send(ma, mb, 0, 0, 0, me, 0);
        wait_idle();
        chk1("C04", C[0][4], 1008);
        chk1("C40", C[4][0], 1064);
        chk1("C77", C[7][7], 1126);

        // (64>>>2) - (8>>>1) = 12
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = 64; mb[r][c] = 8; me[r][c] = 12;
            end
        send(ma, mb, 2, 1, 1, me, 0);
        wait_idle();

        // -5 >>> 31 = -1
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = -5; mb[r][c] = 0; me[r][c] = 32'hFFFF_FFFF;
            end
        send(ma, mb, 31, 0, 0, me, 0);
        wait_idle();

        // Positive overflow in the last element
        ma = '0; mb = '0; me = '0;
        ma[7][7] = 32'h7FFF_FFFF; mb[7][7] = 1;
`ifdef MATRIX_ADD_SAT_EN
        me[7][7] = 32'h7FFF_FFFF;
`else
        me[7][7] = 32'h8000_0000;
`endif
        send(ma, mb, 0, 0, 0, me, 1);
        wait_idle();

        // Clean op clears ovf: 3 - 5 = -2
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = 3; mb[r][c] = 5; me[r][c] = 32'hFFFF_FFFE;
            end
        send(ma, mb, 0, 0, 1, me, 0);
        wait_idle();

        // Reset during tile 2 of an overflowing op
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = 32'h7FFF_FFFF; mb[r][c] = 1;
            end
        send(ma, mb, 0, 0, 0, me, 1);
        @(posedge clk); #1;
        chk1("ovf_sticky_mid", ovf, 1);
        @(posedge clk); #1;
        rst_n = 0;
        void'(q.pop_back());
        #1;
        chk1("abort_out_valid", out_valid, 0);
        chk1("abort_ovf", ovf, 0);
        chkm("abort_C", C, '0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        chk1("abort_in_ready", in_ready, 1);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = 8 * r + c;
                mb[r][c] = 1000 + 8 * r + c;
                me[r][c] = 1000 + 2 * (8 * r + c);
            end
        send(ma, mb, 0, 0, 0, me, 0);
        wait_idle();

        // Backpressure with a negative overflow held in DONE
        out_ready = 0;
        ma = '0; mb = '0; me = '0;
        ma[0][0] = 32'h8000_0000; mb[0][0] = 1;
`ifdef MATRIX_ADD_SAT_EN
        me[0][0] = 32'h8000_0000;
`else
        me[0][0] = 32'h7FFF_FFFF;
`endif
        send(ma, mb, 0, 0, 1, me, 1);
        for (int i = 0; i < 20 && !out_valid; i++) begin
            @(posedge clk); #1;
        end
        chk1("bp_reach_done", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            A = '0; B = '0; m_bit1 = 0; m_bit2 = 0; flag = 0;
            @(posedge clk); #1;
            chk1("bp_out_valid", out_valid, 1);
            chk1("bp_in_ready", in_ready, 0);
            chk1("bp_ovf", ovf, 1);
            chkm("bp_C", C, me);
        end
        in_valid = 0;
        out_ready = 1;
        wait_idle();
        chk1("bp_release_out_valid", out_valid, 0);
        chk1("bp_release_in_ready", in_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        chk1("bp_no_capture", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
